shift_collect: RTL

SHIFT_COLLECT -- requirements
Module: shift_collect

---
 rtl/shift_collect.sv | 91 +++++++++
 1 files changed

// File: rtl/shift_collect.sv
// Serial-to-parallel collector: assembles WIDTH-bit words MSB-first and holds the
// last completed word for a ready-style consumer, flagging words dropped while full.
module shift_collect #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic             E,
    input  logic             L,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;
    logic             accept;
    logic             complete;
    logic             load;
    logic             ovr_set;

    assign accept   = E && !L;
    assign complete = accept && (bit_cnt == CW'(WIDTH - 1));
    // The completing bit is folded in here so the word is captured on the same edge.
    assign word     = {sr[WIDTH-2:0], w};

    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (L) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            sr      <= word;
            bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            out_data <= '0;
            overrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load)
                out_data <= word;
            if (ovr_set)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ovr_set   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (complete) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    if (out_ready)
                        load = 1'b1;
                    else
                        ovr_set = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

endmodule
